// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer gain sequencer: default sizing,
// unity gain constant, gain type and the sequencer state encoding.
package eq_pkg;

    localparam int NUMBER_OF_FILTERS = 8;
    localparam int GAIN_BITS         = 8;
    localparam int GAIN_FRAC_BITS    = 2;
    localparam int BAND_ADDR_BITS    = 3;
    localparam int RAMP_STEP         = 1;

    typedef logic signed [GAIN_BITS-1:0] gain_t;

    localparam gain_t UNITY_GAIN = gain_t'(1 << GAIN_FRAC_BITS);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        DONE
    } state_t;

endpackage

// File: rtl/eq_gain_ramp_lane.sv
// One band of live gain: steps toward its target on each enabled cycle without
// overshoot. Gradual stepping only with EQ_GAIN_RAMP_EN, otherwise a direct copy.
module eq_gain_ramp_lane #(
    parameter int GAIN_BITS      = eq_pkg::GAIN_BITS,
    parameter int GAIN_FRAC_BITS = eq_pkg::GAIN_FRAC_BITS,
    parameter int RAMP_STEP      = eq_pkg::RAMP_STEP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        step_en,
    input  logic signed [GAIN_BITS-1:0] target,
    output logic signed [GAIN_BITS-1:0] live,
    output logic                        at_target
);

`ifdef EQ_GAIN_RAMP_EN
    localparam bit GRADUAL = 1'b1;
`else
    localparam bit GRADUAL = 1'b0;
`endif

    localparam logic signed [GAIN_BITS:0]   STEP  = (GAIN_BITS+1)'(RAMP_STEP);
    localparam logic signed [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1 << GAIN_FRAC_BITS);

    logic signed [GAIN_BITS:0]   diff;
    logic signed [GAIN_BITS-1:0] live_nx;

    // One extra bit keeps the difference exact across the full signed range.
    always_comb begin
        diff    = {target[GAIN_BITS-1], target} - {live[GAIN_BITS-1], live};
        live_nx = target;
        if (GRADUAL) begin
            if (diff > STEP) begin
                live_nx = live + STEP[GAIN_BITS-1:0];
            end else if (diff < -STEP) begin
                live_nx = live - STEP[GAIN_BITS-1:0];
            end
        end
    end

    assign at_target = (live == target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live <= UNITY;
        end else if (step_en) begin
            live <= live_nx;
        end
    end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Gain sequencer: shadow bank written over valid/ready, commit ramps the live
// amplifier gains toward it on sample strobes (gradual only with EQ_GAIN_RAMP_EN).
module eq_gain_sequencer #(
    parameter int NUMBER_OF_FILTERS = eq_pkg::NUMBER_OF_FILTERS,
    parameter int GAIN_BITS         = eq_pkg::GAIN_BITS,
    parameter int GAIN_FRAC_BITS    = eq_pkg::GAIN_FRAC_BITS,
    parameter int BAND_ADDR_BITS    = eq_pkg::BAND_ADDR_BITS,
    parameter int RAMP_STEP         = eq_pkg::RAMP_STEP
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_enable,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [BAND_ADDR_BITS-1:0]              cfg_band,
    input  logic [GAIN_BITS-1:0]                   cfg_gain,
    input  logic                                   cfg_commit,
    output logic                                   busy,
    output logic                                   ramp_done,
    output logic                                   cfg_err,
    output logic                                   amplifier_enable,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains
);

    import eq_pkg::*;

    localparam logic signed [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1 << GAIN_FRAC_BITS);

    state_t                      state;
    state_t                      state_nx;
    logic                        write_en;
    logic                        step_en;
    logic                        band_ok;
    logic                        all_at_target;
    logic [NUMBER_OF_FILTERS-1:0] at_target;
    logic signed [GAIN_BITS-1:0] shadow [NUMBER_OF_FILTERS];

    assign band_ok       = int'(cfg_band) < NUMBER_OF_FILTERS;
    assign all_at_target = &at_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        ramp_done = 1'b0;
        write_en  = 1'b0;
        step_en   = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                write_en  = cfg_valid;
                if (cfg_commit) begin
                    state_nx = RAMP;
                end
            end
            RAMP: begin
                busy = 1'b1;
                if (all_at_target) begin
                    state_nx = DONE;
                end else begin
                    step_en = clk_enable;
                end
            end
            DONE: begin
                busy      = 1'b1;
                ramp_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
                shadow[i] <= UNITY;
            end
            cfg_err          <= 1'b0;
            amplifier_enable <= 1'b0;
        end else begin
            if (write_en) begin
                for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
                    if (cfg_band == BAND_ADDR_BITS'(i)) begin
                        shadow[i] <= cfg_gain;
                    end
                end
                if (!band_ok) begin
                    cfg_err <= 1'b1;
                end
            end
            if (state == DONE) begin
                amplifier_enable <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUMBER_OF_FILTERS; i++) begin : g_lane
        eq_gain_ramp_lane #(
            .GAIN_BITS      (GAIN_BITS),
            .GAIN_FRAC_BITS (GAIN_FRAC_BITS),
            .RAMP_STEP      (RAMP_STEP)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .step_en   (step_en),
            .target    (shadow[i]),
            .live      (amplifier_gains[i*GAIN_BITS +: GAIN_BITS]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Bench for eq_gain_sequencer: two instances (8 bands/step 1, 6 bands/step 4)
// share stimulus; a behavioural model is compared every cycle plus literals.
module tb_eq_gain_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_enable = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_band = '0;
    logic [7:0]  cfg_gain = '0;
    logic        cfg_commit = 1'b0;

    logic        r8, b8, d8, e8, en8;
    logic        r6, b6, d6, e6, en6;
    logic [63:0] g8;
    logic [47:0] g6;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    eq_gain_sequencer #(
        .NUMBER_OF_FILTERS (8),
        .GAIN_BITS         (8),
        .GAIN_FRAC_BITS    (2),
        .BAND_ADDR_BITS    (3),
        .RAMP_STEP         (1)
    ) u8 (
        .clk (clk), .rst (rst), .clk_enable (clk_enable),
        .cfg_valid (cfg_valid), .cfg_ready (r8), .cfg_band (cfg_band),
        .cfg_gain (cfg_gain), .cfg_commit (cfg_commit), .busy (b8),
        .ramp_done (d8), .cfg_err (e8), .amplifier_enable (en8),
        .amplifier_gains (g8)
    );

    eq_gain_sequencer #(
        .NUMBER_OF_FILTERS (6),
        .GAIN_BITS         (8),
        .GAIN_FRAC_BITS    (2),
        .BAND_ADDR_BITS    (3),
        .RAMP_STEP         (4)
    ) u6 (
        .clk (clk), .rst (rst), .clk_enable (clk_enable),
        .cfg_valid (cfg_valid), .cfg_ready (r6), .cfg_band (cfg_band),
        .cfg_gain (cfg_gain), .cfg_commit (cfg_commit), .busy (b6),
        .ramp_done (d6), .cfg_err (e6), .amplifier_enable (en6),
        .amplifier_gains (g6)
    );

`ifdef EQ_GAIN_RAMP_EN
    localparam bit GRAD = 1'b1;
`else
    localparam bit GRAD = 1'b0;
`endif

    // Behavioural model: index 0 = u8, index 1 = u6.
    int n_of  [2] = '{8, 6};
    int st_of [2] = '{1, 4};
    int sh [2][8];
    int lv [2][8];
    bit ramping [2];
    bit fin     [2];
    bit en_m    [2];
    bit err_m   [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 8; b++) begin
                sh[k][b] = 4;
                lv[k][b] = 4;
            end
            ramping[k] = 1'b0;
            fin[k]     = 1'b0;
            en_m[k]    = 1'b0;
            err_m[k]   = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k);
        bit eq_all;
        int d;
        if (fin[k]) begin
            fin[k]  = 1'b0;
            en_m[k] = 1'b1;
        end else if (ramping[k]) begin
            eq_all = 1'b1;
            for (int b = 0; b < n_of[k]; b++) if (lv[k][b] != sh[k][b]) eq_all = 1'b0;
            if (eq_all) begin
                ramping[k] = 1'b0;
                fin[k]     = 1'b1;
            end else if (clk_enable) begin
                for (int b = 0; b < n_of[k]; b++) begin
                    d = sh[k][b] - lv[k][b];
                    if (GRAD && d > st_of[k])       lv[k][b] = lv[k][b] + st_of[k];
                    else if (GRAD && d < -st_of[k]) lv[k][b] = lv[k][b] - st_of[k];
                    else                            lv[k][b] = sh[k][b];
                end
            end
        end else begin
            if (cfg_valid) begin
                if (int'(cfg_band) < n_of[k]) sh[k][int'(cfg_band)] = int'($signed(cfg_gain));
                else err_m[k] = 1'b1;
            end
            if (cfg_commit) ramping[k] = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        logic [63:0] x8;
        logic [47:0] x6;
        if (chk_on) begin
            x8 = '0;
            x6 = '0;
            for (int b = 0; b < 8; b++) x8[b*8 +: 8] = lv[0][b][7:0];
            for (int b = 0; b < 6; b++) x6[b*8 +: 8] = lv[1][b][7:0];
            chk("gains8", g8, x8);
            chk("ready8", r8, !(ramping[0] || fin[0]));
            chk("busy8",  b8, ramping[0] || fin[0]);
            chk("done8",  d8, fin[0]);
            chk("err8",   e8, err_m[0]);
            chk("en8",    en8, en_m[0]);
            chk("gains6", g6, x6);
            chk("ready6", r6, !(ramping[1] || fin[1]));
            chk("busy6",  b6, ramping[1] || fin[1]);
            chk("done6",  d6, fin[1]);
            chk("err6",   e6, err_m[1]);
            chk("en6",    en6, en_m[1]);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(r8 && r6) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL wait_idle timeout act=busy exp=idle t=%0t", $time);
        end
    endtask

    task automatic wr(input int b, input int g, input bit valid, input bit commit);
        wait_idle();
        cfg_valid  = valid;
        cfg_band   = 3'(b);
        cfg_gain   = 8'(g);
        cfg_commit = commit;
        @(posedge clk); #1;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Counts edges from the commit-accept edge to the first ramp_done cycle.
    task automatic lat(input int x8, input int x6);
        int n = 0;
        int l8 = 0;
        int l6 = 0;
        while ((l8 == 0 || l6 == 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (d8 && l8 == 0) l8 = n;
            if (d6 && l6 == 0) l6 = n;
        end
        chk("lat8", 64'(l8), 64'(x8));
        chk("lat6", 64'(l6), 64'(x6));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_g8", g8, 64'h0404040404040404);
        chk("rst_g6", g6, 48'h040404040404);
        chk("rst_rdy8", r8, 1'b1);
        chk("rst_busy8", b8, 1'b0);
        chk("rst_en8", en8, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Band 3 to 43.
        wr(3, 43, 1'b1, 1'b1);
        if (GRAD) lat(40, 11);
        else      lat(2, 2);
        wait_idle();
        chk("t1_g8", g8, 64'h040404042B040404);
        chk("t1_g6", g6, 48'h04042B040404);
        chk("t1_en8", en8, 1'b1);
        chk("t1_en6", en6, 1'b1);

        // Band 0 to -8, band 5 and 7 to 20 (7 is out of range for u6).
        wr(0, -8, 1'b1, 1'b0);
        wr(5, 20, 1'b1, 1'b0);
        wr(7, 20, 1'b1, 1'b1);
        if (GRAD) lat(17, 5);
        else      lat(2, 2);
        wait_idle();
        chk("t2_g8", g8, 64'h140414042B0404F8);
        chk("t2_g6", g6, 48'h14042B0404F8);
        chk("t2_err6", e6, 1'b1);
        chk("t2_err8", e8, 1'b0);

        // Sparse strobes with write attempts during the ramp.
        clk_enable = 1'b0;
        wr(1, -3, 1'b1, 1'b1);
        for (int c = 0; c < 600; c++) begin
            clk_enable = (c % 64 == 63);
            cfg_valid  = (c < 400) && (c % 50 == 10);
            cfg_band   = 3'd2;
            cfg_gain   = 8'd99;
            @(posedge clk); #1;
        end
        cfg_valid  = 1'b0;
        clk_enable = 1'b1;
        wait_idle();
        chk("t3_g8", g8, 64'h140414042B04FDF8);
        chk("t3_g6", g6, 48'h14042B04FDF8);
        chk("t3_err6_sticky", e6, 1'b1);

        // Reset in the middle of a ramp.
        wr(3, 0, 1'b1, 1'b1);
        repeat (23) begin
            @(posedge clk); #1;
        end
`ifdef EQ_GAIN_RAMP_EN
        chk("t4_mid_b3", g8[31:24], 8'd20);
`endif
        rst = 1'b0;
        #1;
        chk("t4_g8", g8, 64'h0404040404040404);
        chk("t4_g6", g6, 48'h040404040404);
        chk("t4_rdy8", r8, 1'b1);
        chk("t4_busy8", b8, 1'b0);
        chk("t4_err6", e6, 1'b0);
        chk("t4_en8", en8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Commit with nothing to change.
        wr(0, 4, 1'b1, 1'b1);
        lat(1, 1);
        wait_idle();
        chk("t5_g8", g8, 64'h0404040404040404);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eq_gain_sequencer.md
Name: eq_gain_sequencer

Overview:
- Configuration controller for the equalizer's amplifier stage.
- Host writes per-band target gains into a shadow bank over a valid/ready port; a commit request starts the update.
- Live gains on amplifier_gains then move one step per sample strobe (clk_enable) toward the targets, so settings never jump and cause zipper noise.
- Sits between the host/register interface and the equalizer's amplifier_gains/amplifier_enable inputs.

Parameters:
- NUMBER_OF_FILTERS, 8, number of bands.
- GAIN_BITS, 8, signed gain width (fixed-point).
- GAIN_FRAC_BITS, 2, fractional bits of gain; unity = 2**GAIN_FRAC_BITS.
- BAND_ADDR_BITS, 3, width of band index.
- RAMP_STEP, 1, gain LSBs moved per strobe; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clk_enable  in  1  sample strobe, same signal that enables the equalizer.
- cfg_valid  in  1  gain write request.
- cfg_ready  out  1  write/commit accepted this cycle.
- cfg_band  in  BAND_ADDR_BITS  band index; 0 = lpf_1000hz … N-1 = hpf_7000hz.
- cfg_gain  in  GAIN_BITS  signed target gain.
- cfg_commit  in  1  start update, sampled only when cfg_ready=1.
- busy  out  1  update in progress.
- ramp_done  out  1  one-cycle pulse when all live gains equal their targets.
- cfg_err  out  1  sticky flag: write to band >= NUMBER_OF_FILTERS.
- amplifier_enable  out  1  to equalizer.
- amplifier_gains  out  NUMBER_OF_FILTERS*GAIN_BITS  live gains; band i at [(i+1)*GAIN_BITS-1 : i*GAIN_BITS].

Behaviour:
- Reset (rst=0, async) drives:
  - shadow and live gains: every band = unity (4 at defaults)
  - amplifier_enable = 0
  - busy = 0, ramp_done = 0, cfg_err = 0
  - cfg_ready = 1 (state IDLE)
- FSM states IDLE, RAMP, DONE:
  - IDLE: cfg_ready=1. A write happens when cfg_valid=1 and cfg_ready=1:
    - band < N: shadow[band] <= cfg_gain
    - band >= N: shadow unchanged, cfg_err <= 1 (stays set until reset); the handshake still completes.
  - IDLE -> RAMP: cfg_commit=1. If cfg_valid=1 in the same cycle, the write lands first and the ramp uses the updated shadow.
  - RAMP: cfg_ready=0, busy=1; cfg_valid and cfg_commit are ignored. On each cycle with clk_enable=1, every band with live != shadow steps toward shadow:
    - step size = min(RAMP_STEP, |shadow - live|); no overshoot.
    - difference computed signed in GAIN_BITS+1 bits; no wrap-around.
  - RAMP -> DONE: first cycle in which every live gain equals its shadow, checked every clk, independent of clk_enable. A commit with nothing to change therefore leaves RAMP after 1 cycle.
  - DONE: ramp_done=1 and busy=1 for exactly one cycle; amplifier_enable <= 1 (stays 1 until reset). DONE -> IDLE unconditionally.
- clk_enable=0 during RAMP stalls the live gains; the FSM stays in RAMP.
- Live-gain register updates are registered: a step taken on a strobe at cycle t is visible on amplifier_gains at cycle t+1.
- Timing: latency from commit acceptance to ramp_done = (max over bands of ceil(|delta|/RAMP_STEP)) strobes, plus 1 cycle for DONE.
- Reset asserted mid-ramp: live and shadow both return to unity immediately; the partial ramp is discarded.

Optional Feature:
- Macro EQ_GAIN_RAMP_EN.
- Defined: gradual stepping as above.
- Undefined: in RAMP, the first clk_enable=1 cycle copies all shadow gains to live at once. DONE follows on the next cycle; RAMP_STEP is unused.

Decomposition:
- Shared package eq_pkg holds:
  - NUMBER_OF_FILTERS, GAIN_BITS, GAIN_FRAC_BITS
  - UNITY_GAIN constant
  - gain_t typedef (signed GAIN_BITS)
  - state enum (IDLE/RAMP/DONE)
- One natural sub-module, eq_gain_ramp_lane, instantiated once per band:
  - holds the live register for its band
  - does the saturating step toward its target
  - outputs an "at_target" flag
- Top level ANDs the at_target flags and runs the FSM.

Test Plan:
- Reset release: amplifier_gains = 0x0404040404040404, cfg_ready=1, busy=0, amplifier_enable=0.
- Write band 3 = 43 (10.75), commit, clk_enable every cycle, RAMP_STEP=1 -> band 3 goes 4,5,…,43 over 39 strobes; ramp_done pulses once; amplifier_enable=1; other bands stay 4.
- RAMP_STEP=4:
  - band 0 target -8 -> 0, -4, -8 after 3 strobes.
  - band 7 target 20 reached 5,4 steps, i.e. 4 strobes -> ramp_done after the 4th strobe + 1 cycle.
- clk_enable once per 64 cycles during a ramp: gains change only on strobe cycles; cfg_valid pulses in RAMP are ignored (cfg_ready=0, shadow unchanged).
- NUMBER_OF_FILTERS=6, write band 7 -> cfg_err=1 and sticky; amplifier_gains unchanged after a commit.
- Assert rst=0 mid-ramp on band 3 at value 20 -> immediately all gains 4 and state IDLE.
- Without EQ_GAIN_RAMP_EN -> the commit completes on the first strobe.
